// File: rtl/sync_fifo_stream_reader_if.sv
// Signal bundle between a synchronous FIFO read port, the stream reader and its consumer.
// Stream handshake: a word transfers on a rising edge where out_valid && out_ready; out_valid/out_data hold until then.
interface sync_fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 3
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  buf_count;
  logic [CNT_WIDTH-1:0]  inflight_cnt;

  modport master (
    output fifo_rd_en, out_valid, out_data, buf_count, inflight_cnt,
    input  fifo_dout, fifo_empty, out_ready
  );

  modport slave (
    input  fifo_rd_en, out_valid, out_data, buf_count, inflight_cnt,
    output fifo_dout, fifo_empty, out_ready
  );
endinterface

// File: rtl/sync_fifo_stream_reader.sv
// Prefetching adapter from a fixed-latency FIFO read port to a registered valid/ready stream.
// Reads are issued from registered occupancy only, so out_ready never reaches fifo_rd_en.
module sync_fifo_stream_reader #(
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH    = READ_LATENCY + 2,
  parameter int CNT_WIDTH    = $clog2(BUF_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  sync_fifo_stream_reader_if.master  bus
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_WIDTH:0] DEPTH_EXT = BUF_DEPTH[CNT_WIDTH:0];

  logic [DATA_WIDTH-1:0]   mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]    occ_q, occ_d;
  logic [CNT_WIDTH-1:0]    infl_q, infl_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic [READ_LATENCY:0]   tag_ext;
  logic [CNT_WIDTH:0]      pending;
  logic                    rd_en;
  logic                    cap;
  logic                    pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reserve a slot for every outstanding read so a capture can never overflow.
  assign pending = {1'b0, occ_q} + {1'b0, infl_q};
  assign rd_en   = rst && !bus.fifo_empty && (pending < DEPTH_EXT);
  assign cap     = tag_q[READ_LATENCY-1];
  assign pop     = bus.out_valid && bus.out_ready;
  assign tag_ext = {tag_q, rd_en};

  always_comb begin
    tag_d    = tag_ext[READ_LATENCY-1:0];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    infl_d   = infl_q;
    if (cap) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({cap, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    case ({rd_en, cap})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
    end
  end

  // Storage is cleared on reset so out_data reads as zero until the first capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (cap) begin
      mem_q[wr_ptr_q] <= bus.fifo_dout;
    end
  end

  assign bus.fifo_rd_en   = rd_en;
  assign bus.out_valid    = (occ_q != '0);
  assign bus.out_data     = mem_q[rd_ptr_q];
  assign bus.buf_count    = occ_q;
  assign bus.inflight_cnt = infl_q;
endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for sync_fifo_stream_reader: READ_LATENCY=1 and =2 instances share one stimulus stream.
module tb_sync_fifo_stream_reader;
  localparam int W  = 64;
  localparam int CW = 3;
  localparam int D0 = 3;
  localparam int D1 = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_stream_reader_if #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) bus0 ();
  sync_fifo_stream_reader_if #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) bus1 ();

  sync_fifo_stream_reader #(.DATA_WIDTH(W), .READ_LATENCY(1), .BUF_DEPTH(D0), .CNT_WIDTH(CW))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sync_fifo_stream_reader #(.DATA_WIDTH(W), .READ_LATENCY(2), .BUF_DEPTH(D1), .CNT_WIDTH(CW))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [W-1:0] dout0 = '0;
  logic [W-1:0] stage1 = '0;
  logic [W-1:0] dout1 = '0;
  logic         emp0 = 1'b1;
  logic         emp1 = 1'b1;
  logic         rdy = 1'b0;

  assign bus0.fifo_dout  = dout0;
  assign bus0.fifo_empty = emp0;
  assign bus0.out_ready  = rdy;
  assign bus1.fifo_dout  = dout1;
  assign bus1.fifo_empty = emp1;
  assign bus1.out_ready  = rdy;

  // FIFO contents and scoreboards
  logic [W-1:0] fq0[$];
  logic [W-1:0] fq1[$];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int checks = 0;
  int errors = 0;
  int rd_cnt0 = 0;
  int pop_cnt0 = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    fq0.push_back(w);
    fq1.push_back(w);
    exp_q0.push_back(w);
    exp_q1.push_back(w);
    emp0 = 1'b0;
    emp1 = 1'b0;
  endtask

  // One clock: sample at mid-cycle, then model the FIFO read port just after the edge.
  task automatic step();
    logic re0, re1;
    #1;
    re0 = bus0.fifo_rd_en;
    re1 = bus1.fifo_rd_en;
    chk("rd_underflow0", re0 && (fq0.size() == 0), 0);
    chk("rd_underflow1", re1 && (fq1.size() == 0), 0);
    chk("occ_bound0", (int'(bus0.buf_count) + int'(bus0.inflight_cnt)) <= D0, 1);
    chk("occ_bound1", (int'(bus1.buf_count) + int'(bus1.inflight_cnt)) <= D1, 1);
    if (re0) rd_cnt0++;
    if (bus0.out_valid && rdy) begin
      pop_cnt0++;
      chk("sb0_nonempty", exp_q0.size() != 0, 1);
      if (exp_q0.size() != 0) chk("sb0_data", bus0.out_data, exp_q0.pop_front());
    end
    if (bus1.out_valid && rdy) begin
      chk("sb1_nonempty", exp_q1.size() != 0, 1);
      if (exp_q1.size() != 0) chk("sb1_data", bus1.out_data, exp_q1.pop_front());
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      fq0.delete();
      fq1.delete();
      exp_q0.delete();
      exp_q1.delete();
      dout0 = '0;
      stage1 = '0;
      dout1 = '0;
    end else begin
      dout1  = stage1;
      stage1 = (re1 && fq1.size() != 0) ? fq1.pop_front() : {$urandom, $urandom};
      dout0  = (re0 && fq0.size() != 0) ? fq0.pop_front() : {$urandom, $urandom};
    end
    emp0 = (fq0.size() == 0);
    emp1 = (fq1.size() == 0);
    @(negedge clk);
  endtask

  initial begin
    int pushed;
    int g;
    @(negedge clk);

    // reset state and streaming with out_ready held high
    rdy = 1'b1;
    rst = 1'b0;
    repeat (3) step();
    chk("rst_valid0", bus0.out_valid, 0);
    chk("rst_count0", bus0.buf_count, 0);
    chk("rst_data0", bus0.out_data, 0);
    chk("rst_rden0", bus0.fifo_rd_en, 0);
    chk("rst_valid1", bus1.out_valid, 0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) push(W'(8'h10 + i));
    #1;
    chk("t1_rd_first", bus0.fifo_rd_en, 1);
    chk("t1_valid_c0", bus0.out_valid, 0);
    step();
    chk("t1_valid_c1", bus0.out_valid, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("t1_stream_valid", bus0.out_valid, 1);
      chk("t1_stream_data", bus0.out_data, W'(8'h10 + i));
      step();
    end
    chk("t1_idle_valid", bus0.out_valid, 0);
    chk("t1_idle_count", bus0.buf_count, 0);
    repeat (6) step();
    chk("t1_sb1_drained", exp_q1.size(), 0);

    // back-pressure: buffer fills, reads stop, head word holds
    rdy = 1'b0;
    rd_cnt0 = 0;
    for (int i = 0; i < 8; i++) push(W'(8'h10 + i));
    repeat (6) step();
    chk("t2_reads", rd_cnt0, 3);
    chk("t2_count", bus0.buf_count, 3);
    chk("t2_rden", bus0.fifo_rd_en, 0);
    chk("t2_valid", bus0.out_valid, 1);
    chk("t2_data", bus0.out_data, 64'h10);
    repeat (2) step();
    chk("t2_data_hold", bus0.out_data, 64'h10);
    chk("t2_reads_hold", rd_cnt0, 3);
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_valid", bus0.out_valid, 1);
      chk("t2_drain_data", bus0.out_data, W'(8'h10 + i));
      step();
    end
    chk("t2_reads_total", rd_cnt0, 8);
    repeat (10) step();
    chk("t2_sb0_drained", exp_q0.size(), 0);
    chk("t2_sb1_drained", exp_q1.size(), 0);

    // random back-pressure with 1000 random words
    pushed = 0;
    while (pushed < 1000) begin
      rdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        push({$urandom, $urandom});
        pushed++;
      end
      step();
    end
    rdy = 1'b1;
    g = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && g < 100) begin
      step();
      g++;
    end
    chk("t3_drained0", exp_q0.size(), 0);
    chk("t3_drained1", exp_q1.size(), 0);

    // single word in the FIFO
    repeat (2) step();
    rd_cnt0 = 0;
    pop_cnt0 = 0;
    push(64'hAB);
    repeat (8) step();
    chk("t4_reads", rd_cnt0, 1);
    chk("t4_pops", pop_cnt0, 1);
    chk("t4_rden", bus0.fifo_rd_en, 0);
    chk("t4_valid", bus0.out_valid, 0);

    // reset with two buffered words and one read in flight
    rdy = 1'b0;
    for (int i = 0; i < 10; i++) push(W'(16'h300 + i));
    g = 0;
    while (!(bus0.buf_count == 2 && bus0.inflight_cnt == 1) && g < 20) begin
      step();
      g++;
    end
    chk("t5_reached", (bus0.buf_count == 2) && (bus0.inflight_cnt == 1), 1);
    rst = 1'b0;
    #1;
    chk("t5_rden_forced", bus0.fifo_rd_en, 0);
    step();
    chk("t5_valid", bus0.out_valid, 0);
    chk("t5_count", bus0.buf_count, 0);
    chk("t5_inflight", bus0.inflight_cnt, 0);
    chk("t5_data", bus0.out_data, 0);
    rst = 1'b1;
    #1;
    chk("t5_rden", bus0.fifo_rd_en, 0);
    repeat (3) step();
    chk("t5_no_late_count", bus0.buf_count, 0);
    chk("t5_no_late_valid", bus0.out_valid, 0);
    chk("t5_no_late_count1", bus1.buf_count, 0);

    // capture and pop in the same cycle with one word buffered
    rdy = 1'b1;
    push(64'h20);
    push(64'h21);
    push(64'h22);
    g = 0;
    while (!bus0.out_valid && g < 10) begin
      step();
      g++;
    end
    chk("t6_count_a", bus0.buf_count, 1);
    chk("t6_inflight_a", bus0.inflight_cnt, 1);
    chk("t6_data_a", bus0.out_data, 64'h20);
    step();
    chk("t6_count_b", bus0.buf_count, 1);
    chk("t6_data_b", bus0.out_data, 64'h21);
    repeat (8) step();
    chk("t6_sb0_drained", exp_q0.size(), 0);
    chk("t6_sb1_drained", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_stream_reader.md
Name: sync_fifo_stream_reader

Overview:
- Read-side adapter for the team's synchronous FIFOs, which expose a standard-mode read port: rd_en, dout valid a fixed number of cycles later, and empty.
- Converts that port into a registered valid/ready stream that downstream pipeline stages consume with back-pressure.
- Prefetches words into a small internal buffer, giving full throughput (one word per cycle) with no combinational path from out_ready to fifo_rd_en.
- Sits between any synchronous FIFO instance and its consumer.

Parameters:
- DATA_WIDTH, 64: width of fifo_dout and out_data.
- READ_LATENCY, 1: cycles from fifo_rd_en high to fifo_dout valid. Legal values are 1 and 2.
- BUF_DEPTH, READ_LATENCY+2: internal buffer entries. Must be at least READ_LATENCY+2.
- CNT_WIDTH, log2b(BUF_DEPTH)+1: width of occupancy and in-flight counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets the block).
- fifo_rd_en  out  1  read strobe to the FIFO.
- fifo_dout  in  DATA_WIDTH  FIFO read data, valid READ_LATENCY cycles after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  DATA_WIDTH  head-of-buffer word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- buf_count  out  CNT_WIDTH  words currently held in the internal buffer.

Behaviour:
- State:
  - circular buffer mem[BUF_DEPTH] with wr_ptr/rd_ptr (wrap at BUF_DEPTH-1 -> 0);
  - occ = buffered words;
  - inflight = issued reads not yet captured;
  - tag shift register, READ_LATENCY bits long.
- Reset (rst==0 at an edge):
  - occ, inflight, wr_ptr, rd_ptr and tags all go to 0.
  - out_valid=0, buf_count=0, out_data=0.
  - While rst==0, fifo_rd_en is forced to 0.
- Issue rule:
  - fifo_rd_en = rst && !fifo_empty && (occ + inflight) < BUF_DEPTH.
  - It depends only on registered state and fifo_empty, never on out_ready.
- Tag pipeline: tag[0] <= fifo_rd_en. tag[i] <= tag[i-1]. The capture strobe cap = tag[READ_LATENCY-1].
- Capture: when cap==1, mem[wr_ptr] <= fifo_dout and wr_ptr advances.
- Pop: pop = out_valid && out_ready. On pop, rd_ptr advances.
- Counter updates:
  - occ_next = occ + cap - pop.
  - inflight_next = inflight + fifo_rd_en - cap.
  - Simultaneous cap and pop leaves occ unchanged.
- Outputs:
  - out_valid = (occ != 0); out_data = mem[rd_ptr]; buf_count = occ. All are derived from registered state.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Latency: when fifo_empty falls at cycle T with the buffer idle:
  - fifo_rd_en goes high in cycle T;
  - out_valid goes high in cycle T+READ_LATENCY+1.
- Throughput: with out_ready held at 1 and the FIFO non-empty, one word is delivered per cycle in steady state.
- Ordering: words leave in exactly FIFO order. None are dropped or duplicated.
- Overflow safety: occ + inflight <= BUF_DEPTH always, so a capture never lands in a full buffer.
- Empty-buffer pop: impossible by construction, since out_valid is 0 when occ is 0.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO shares the same reset domain, so the stream restarts cleanly.
- fifo_empty rising while reads are in flight: in-flight reads still complete and are captured.

Test Plan:
- Reset, then FIFO preloaded with 0x10..0x17 and out_ready=1 (READ_LATENCY=1) -> fifo_rd_en high from the first cycle after reset; out_valid at cycle +2; words 0x10..0x17 on consecutive cycles; then out_valid=0 and buf_count=0.
- Same preload, out_ready=0 -> exactly BUF_DEPTH=3 reads issued; buf_count=3; fifo_rd_en stays 0; out_data=0x10 held stable. Raising out_ready then drains 0x10..0x17 in order with no gaps after the first.
- Random out_ready (50%) with 1000 random words, run for READ_LATENCY=1 and READ_LATENCY=2 -> output sequence equals the input sequence; occ+inflight never exceeds BUF_DEPTH.
- FIFO holds 1 word, out_ready=1 -> a single fifo_rd_en pulse; one out_valid pulse carrying that word; no further reads while fifo_empty=1.
- rst driven low for 1 cycle while buf_count=2 and inflight=1 -> next cycle out_valid=0, buf_count=0, fifo_rd_en=0. The late FIFO data is not captured.
- Simultaneous capture and pop with occ=1 -> occ remains 1 and out_data advances to the next word.
